// File: rtl/memmap_pkg.sv
// Shared types and constants for the MEMORYMAP arbiter slice.
//   state_e          : sequencer state (IDLE -> ACCESS -> RESP -> IDLE)
//   owner_e          : owner id, also the encoding of the grant output
//   PS2_ADDR_DEFAULT : memory-map slot reserved for the PS2 keycode word
package memmap_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_PS2  = 2'd1,
        OWN_CPU  = 2'd2,
        OWN_VGA  = 2'd3
    } owner_e;

    localparam logic [5:0] PS2_ADDR_DEFAULT = 6'd62;

endpackage

// File: rtl/memmap_arbiter_if.sv
// Bundle of every requester handshake plus the MEMORYMAP port.
//   slave  : the arbiter side (takes requests, drives acks and the memory port)
//   master : the requester / memory side
interface memmap_arbiter_if #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_ack;
    logic [DATA_W-1:0] cpu_rdata;

    logic              ps2_valid;
    logic [DATA_W-1:0] ps2_data;
    logic              ps2_ready;

    logic              vga_req;
    logic [ADDR_W-1:0] vga_addr;
    logic              vga_ack;
    logic [DATA_W-1:0] vga_rdata;

    logic [ADDR_W-1:0] mm_dir;
    logic [DATA_W-1:0] mm_dataWrite;
    logic              mm_WE;
    logic [DATA_W-1:0] mm_readData;

    logic [1:0]        grant;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  ps2_valid, ps2_data,
        input  vga_req, vga_addr,
        input  mm_readData,
        output cpu_ack, cpu_rdata, ps2_ready, vga_ack, vga_rdata,
        output mm_dir, mm_dataWrite, mm_WE, grant
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output ps2_valid, ps2_data,
        output vga_req, vga_addr,
        output mm_readData,
        input  cpu_ack, cpu_rdata, ps2_ready, vga_ack, vga_rdata,
        input  mm_dir, mm_dataWrite, mm_WE, grant
    );

endinterface

// File: rtl/memmap_prio_sel.sv
// Priority pick PS2 > CPU > VGA with a VGA anti-starvation override.
// Ports:
//   clk, reset     : clock, asynchronous active-low reset
//   ps2_valid, cpu_req, vga_req : pending requests
//   sample         : the sequencer is in IDLE and will consume winner
//   vga_busy       : VGA currently owns the port (its own transaction)
//   winner         : owner id chosen from the current requests
module memmap_prio_sel
    import memmap_pkg::*;
#(
    parameter int STARVE_MAX = 8
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   ps2_valid,
    input  logic   cpu_req,
    input  logic   vga_req,
    input  logic   sample,
    input  logic   vga_busy,
    output owner_e winner
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0] starve_cnt_reg;
    logic             vga_served;

    always_comb begin
        winner = OWN_NONE;
        if (vga_req && starve_cnt_reg == CNT_MAX) begin
            winner = OWN_VGA;
        end else if (ps2_valid) begin
            winner = OWN_PS2;
        end else if (cpu_req) begin
            winner = OWN_CPU;
        end else if (vga_req) begin
            winner = OWN_VGA;
        end
    end

    // VGA's own ACCESS/RESP cycles are not waiting time.
    assign vga_served = vga_busy || (sample && winner == OWN_VGA);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            starve_cnt_reg <= '0;
        end else if (!vga_req || vga_served) begin
            starve_cnt_reg <= '0;
        end else if (starve_cnt_reg != CNT_MAX) begin
            starve_cnt_reg <= starve_cnt_reg + 1'b1;
        end
    end

endmodule

// File: rtl/memmap_arbiter.sv
// Single-port arbiter/sequencer in front of MEMORYMAP, shared by the PS2
// keycode writer, the CPU and the VGA scanner. One transaction at a time:
// IDLE (pick + latch) -> ACCESS (drive port) -> RESP (ack pulse) -> IDLE.
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous active-low reset
//   bus   : requester handshakes, MEMORYMAP port and grant (slave side)
module memmap_arbiter
    import memmap_pkg::*;
#(
    parameter int                ADDR_W     = 6,
    parameter int                DATA_W     = 32,
    parameter logic [ADDR_W-1:0] PS2_ADDR   = ADDR_W'(PS2_ADDR_DEFAULT),
    parameter int                RD_LAT     = 1,
    parameter int                STARVE_MAX = 8
) (
    input  logic             clk,
    input  logic             reset,
    memmap_arbiter_if.slave  bus
);

    localparam int LAT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(RD_LAT - 1);

    state_e            state_reg;
    owner_e            owner_reg;
    owner_e            grant_reg;
    owner_e            winner;
    logic              is_write_reg;
    logic [LAT_W-1:0]  lat_cnt_reg;
    logic [ADDR_W-1:0] mm_dir_reg;
    logic [DATA_W-1:0] mm_data_reg;
    logic              mm_we_reg;
    logic              cpu_ack_reg;
    logic              ps2_ready_reg;
    logic              vga_ack_reg;
    logic [DATA_W-1:0] cpu_rdata_reg;
    logic [DATA_W-1:0] vga_rdata_reg;
    logic              access_done;

    memmap_prio_sel #(
        .STARVE_MAX (STARVE_MAX)
    ) u_sel (
        .clk       (clk),
        .reset     (reset),
        .ps2_valid (bus.ps2_valid),
        .cpu_req   (bus.cpu_req),
        .vga_req   (bus.vga_req),
        .sample    (state_reg == IDLE),
        .vga_busy  (owner_reg == OWN_VGA),
        .winner    (winner)
    );

    // Writes occupy ACCESS for one cycle; reads hold the address RD_LAT cycles.
    assign access_done = is_write_reg || (lat_cnt_reg == LAT_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= IDLE;
            owner_reg     <= OWN_NONE;
            grant_reg     <= OWN_NONE;
            is_write_reg  <= 1'b0;
            lat_cnt_reg   <= '0;
            mm_dir_reg    <= '0;
            mm_data_reg   <= '0;
            mm_we_reg     <= 1'b0;
            cpu_ack_reg   <= 1'b0;
            ps2_ready_reg <= 1'b0;
            vga_ack_reg   <= 1'b0;
            cpu_rdata_reg <= '0;
            vga_rdata_reg <= '0;
        end else begin
            cpu_ack_reg   <= 1'b0;
            ps2_ready_reg <= 1'b0;
            vga_ack_reg   <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (winner != OWN_NONE) begin
                        owner_reg   <= winner;
                        grant_reg   <= winner;
                        lat_cnt_reg <= '0;
                        state_reg   <= ACCESS;
                        case (winner)
                            OWN_PS2: begin
                                mm_dir_reg   <= PS2_ADDR;
                                mm_data_reg  <= bus.ps2_data;
                                is_write_reg <= 1'b1;
                                mm_we_reg    <= 1'b1;
                            end
                            OWN_CPU: begin
                                mm_dir_reg   <= bus.cpu_addr;
                                is_write_reg <= bus.cpu_we;
                                if (bus.cpu_we) begin
                                    mm_data_reg <= bus.cpu_wdata;
                                end
                                // The PS2 slot is owned by the keyboard path:
                                // CPU writes there complete without a strobe.
                                mm_we_reg <= bus.cpu_we && (bus.cpu_addr != PS2_ADDR);
                            end
                            OWN_VGA: begin
                                mm_dir_reg   <= bus.vga_addr;
                                is_write_reg <= 1'b0;
                            end
                            default: ;
                        endcase
                    end
                end
                ACCESS: begin
                    if (access_done) begin
                        mm_we_reg <= 1'b0;
                        grant_reg <= OWN_NONE;
                        state_reg <= RESP;
                        if (!is_write_reg) begin
                            if (owner_reg == OWN_CPU) begin
                                cpu_rdata_reg <= bus.mm_readData;
                            end else if (owner_reg == OWN_VGA) begin
                                vga_rdata_reg <= bus.mm_readData;
                            end
                        end
                        case (owner_reg)
                            OWN_PS2: ps2_ready_reg <= 1'b1;
                            OWN_CPU: cpu_ack_reg   <= 1'b1;
                            OWN_VGA: vga_ack_reg   <= 1'b1;
                            default: ;
                        endcase
                    end else begin
                        lat_cnt_reg <= lat_cnt_reg + 1'b1;
                    end
                end
                RESP: begin
                    // Requests are deliberately not sampled here.
                    owner_reg <= OWN_NONE;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.mm_dir       = mm_dir_reg;
    assign bus.mm_dataWrite = mm_data_reg;
    assign bus.mm_WE        = mm_we_reg;
    assign bus.cpu_ack      = cpu_ack_reg;
    assign bus.cpu_rdata    = cpu_rdata_reg;
    assign bus.ps2_ready    = ps2_ready_reg;
    assign bus.vga_ack      = vga_ack_reg;
    assign bus.vga_rdata    = vga_rdata_reg;
    assign bus.grant        = grant_reg;

endmodule

// File: tb/tb_memmap_arbiter.sv
module tb_memmap_arbiter;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    memmap_arbiter_if bus ();

    memmap_arbiter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural MEMORYMAP: combinational read (RD_LAT=1), write on clock edge.
    logic [31:0] mem [64];
    assign bus.mm_readData = mem[bus.mm_dir];
    always @(posedge clk) begin
        if (bus.mm_WE) mem[bus.mm_dir] <= bus.mm_dataWrite;
    end

    typedef struct packed {
        logic [1:0]  kind;      // 1 PS2, 2 CPU, 3 VGA
        logic        we;
        logic [5:0]  addr;
        logic [31:0] data;
        logic        exp_we;
        logic [5:0]  exp_dir;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic apply_vec(input int idx, input vec_t v);
        logic [2:0]  exp_acks;
        logic [31:0] rd;
        @(posedge clk); #1;
        case (v.kind)
            2'd1: begin bus.ps2_valid = 1'b1; bus.ps2_data = v.data; exp_acks = 3'b100; end
            2'd2: begin
                bus.cpu_req = 1'b1; bus.cpu_we = v.we;
                bus.cpu_addr = v.addr; bus.cpu_wdata = v.data; exp_acks = 3'b010;
            end
            default: begin bus.vga_req = 1'b1; bus.vga_addr = v.addr; exp_acks = 3'b001; end
        endcase
        @(posedge clk); #1;
        chk($sformatf("v%0d_grant", idx), 32'(bus.grant), 32'(v.kind));
        chk($sformatf("v%0d_we", idx), 32'(bus.mm_WE), 32'(v.exp_we));
        chk($sformatf("v%0d_dir", idx), 32'(bus.mm_dir), 32'(v.exp_dir));
        if (v.exp_we) chk($sformatf("v%0d_wdata", idx), bus.mm_dataWrite, v.data);
        @(posedge clk); #1;
        chk($sformatf("v%0d_ack", idx), 32'({bus.ps2_ready, bus.cpu_ack, bus.vga_ack}), 32'(exp_acks));
        chk($sformatf("v%0d_grant0", idx), 32'(bus.grant), 32'd0);
        if (v.kind != 2'd1 && !v.we) begin
            rd = (v.kind == 2'd2) ? bus.cpu_rdata : bus.vga_rdata;
            chk($sformatf("v%0d_rdata", idx), rd, v.exp_rdata);
        end
        bus.ps2_valid = 1'b0; bus.cpu_req = 1'b0; bus.vga_req = 1'b0;
        @(posedge clk); #1;
        chk($sformatf("v%0d_ackdone", idx), 32'({bus.ps2_ready, bus.cpu_ack, bus.vga_ack}), 32'd0);
        $display("vec %0d kind=%0d we=%0d addr=%0d data=%h done", idx, v.kind, v.we, v.addr, v.data);
    endtask

    initial begin
        logic [1:0] seq [8];
        int n;
        int prev_grant;
        int ps2_n, cpu_n, vga_n;

        checks = 0; failures = 0;
        reset = 1'b0;
        bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
        bus.ps2_valid = 0; bus.ps2_data = '0; bus.vga_req = 0; bus.vga_addr = '0;

        //                kind we addr   data          ewe edir  erdata
        vecs[0] = '{2'd2, 1'b1, 6'd1,  32'hFFFF_FFF0, 1'b1, 6'd1,  32'h0};
        vecs[1] = '{2'd2, 1'b0, 6'd1,  32'h0,         1'b0, 6'd1,  32'hFFFF_FFF0};
        vecs[2] = '{2'd1, 1'b1, 6'd0,  32'hFFAF_AFF0, 1'b1, 6'd62, 32'h0};
        vecs[3] = '{2'd2, 1'b0, 6'd62, 32'h0,         1'b0, 6'd62, 32'hFFAF_AFF0};
        vecs[4] = '{2'd2, 1'b1, 6'd62, 32'h0000_1234, 1'b0, 6'd62, 32'h0};
        vecs[5] = '{2'd2, 1'b0, 6'd62, 32'h0,         1'b0, 6'd62, 32'hFFAF_AFF0};
        vecs[6] = '{2'd3, 1'b0, 6'd1,  32'h0,         1'b0, 6'd1,  32'hFFFF_FFF0};
        vecs[7] = '{2'd2, 1'b1, 6'd5,  32'hA5A5_5A5A, 1'b1, 6'd5,  32'h0};
        vecs[8] = '{2'd3, 1'b0, 6'd5,  32'h0,         1'b0, 6'd5,  32'hA5A5_5A5A};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_we", 32'(bus.mm_WE), 32'd0);
        chk("rst_dir", 32'(bus.mm_dir), 32'd0);
        chk("rst_wdata", bus.mm_dataWrite, 32'd0);
        chk("rst_grant", 32'(bus.grant), 32'd0);
        chk("rst_acks", 32'({bus.ps2_ready, bus.cpu_ack, bus.vga_ack}), 32'd0);
        chk("rst_rdata", bus.cpu_rdata | bus.vga_rdata, 32'd0);
        $display("reset state checked");
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 9; i++) apply_vec(i, vecs[i]);

        // Read data registers hold until the next read by the same requester.
        chk("cpu_rdata_hold", bus.cpu_rdata, 32'hFFAF_AFF0);
        chk("vga_rdata_hold", bus.vga_rdata, 32'hA5A5_5A5A);

        // All three requesting together: grants 1, 2, 3, one ack each.
        @(posedge clk); #1;
        bus.ps2_valid = 1; bus.ps2_data = 32'h0000_00AA;
        bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 6'd1;
        bus.vga_req = 1; bus.vga_addr = 6'd5;
        n = 0; prev_grant = 0; ps2_n = 0; cpu_n = 0; vga_n = 0;
        for (int c = 0; c < 15; c++) begin
            @(posedge clk); #1;
            if (bus.grant != 0 && prev_grant == 0) begin
                if (n < 8) seq[n] = bus.grant;
                n++;
            end
            prev_grant = int'(bus.grant);
            if (bus.ps2_ready) begin ps2_n++; bus.ps2_valid = 0; end
            if (bus.cpu_ack)   begin cpu_n++; bus.cpu_req = 0; end
            if (bus.vga_ack)   begin vga_n++; bus.vga_req = 0; end
        end
        bus.ps2_valid = 0; bus.cpu_req = 0; bus.vga_req = 0;
        chk("all3_ngrants", 32'(n), 32'd3);
        chk("all3_g0", 32'(seq[0]), 32'd1);
        chk("all3_g1", 32'(seq[1]), 32'd2);
        chk("all3_g2", 32'(seq[2]), 32'd3);
        chk("all3_ps2_acks", 32'(ps2_n), 32'd1);
        chk("all3_cpu_acks", 32'(cpu_n), 32'd1);
        chk("all3_vga_acks", 32'(vga_n), 32'd1);
        $display("simultaneous request sequence done: %0d grants", n);

        // Starvation: CPU keeps requesting, VGA forced in once counter hits 8.
        @(posedge clk); #1;
        bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 6'd1;
        bus.vga_req = 1; bus.vga_addr = 6'd5;
        n = 0; prev_grant = 0; vga_n = 0;
        for (int c = 0; c < 14; c++) begin
            @(posedge clk); #1;
            if (bus.grant != 0 && prev_grant == 0) begin
                if (n < 8) seq[n] = bus.grant;
                n++;
            end
            prev_grant = int'(bus.grant);
            if (bus.vga_ack) begin
                vga_n++;
                bus.vga_req = 0;
                chk("starve_cnt_clear", 32'(dut.u_sel.starve_cnt_reg), 32'd0);
            end
            if (bus.cpu_ack && n >= 5) bus.cpu_req = 0;
        end
        bus.cpu_req = 0; bus.vga_req = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("starve_ngrants", 32'(n), 32'd5);
        chk("starve_g0", 32'(seq[0]), 32'd2);
        chk("starve_g1", 32'(seq[1]), 32'd2);
        chk("starve_g2", 32'(seq[2]), 32'd2);
        chk("starve_g3", 32'(seq[3]), 32'd3);
        chk("starve_g4", 32'(seq[4]), 32'd2);
        chk("starve_vga_acks", 32'(vga_n), 32'd1);
        chk("starve_vga_rdata", bus.vga_rdata, 32'hA5A5_5A5A);
        $display("starvation sequence done: %0d grants", n);

        // Reset in the middle of a write: WE drops at once, no ack afterwards.
        @(posedge clk); #1;
        bus.cpu_req = 1; bus.cpu_we = 1; bus.cpu_addr = 6'd7; bus.cpu_wdata = 32'h77;
        @(posedge clk); #1;
        chk("midrst_we_before", 32'(bus.mm_WE), 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("midrst_we_after", 32'(bus.mm_WE), 32'd0);
        chk("midrst_grant", 32'(bus.grant), 32'd0);
        bus.cpu_req = 0;
        @(negedge clk);
        reset = 1'b1;
        cpu_n = 0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            if (bus.cpu_ack) cpu_n++;
        end
        chk("midrst_no_ack", 32'(cpu_n), 32'd0);
        $display("mid-transaction reset done");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
